// File: rtl/tweet_tx_if.sv
// Byte-push and status bundle between upstream producers and tweet_tx.
// The master pushes bytes; the slave transmits them and reports FIFO and line state.
interface tweet_tx_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  busy;
    logic                  tx_out;

    modport master (
        output wr_en, wr_data,
        input  full, empty, level, overflow, busy, tx_out
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, level, overflow, busy, tx_out
    );
endinterface

// File: rtl/tweet_tx.sv
// Buffered 8N1 serial transmitter for the tweetboard serial line.
// A small FIFO feeds an LSB-first shifter; consecutive frames are sent back-to-back.
module tweet_tx #(
    parameter int BIT_TICKS  = 5208,
    parameter int CNT_W      = 13,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    tweet_tx_if.slave   t
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_n;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr, rptr, wptr_n, rptr_n;
    logic [DEPTH_LOG2:0] level, level_n;
    logic                full, empty, full_n, empty_n;
    logic                overflow;
    logic                busy;
    logic                tx_out, tx_n;
    logic [CNT_W-1:0]    tick, tick_n;
    logic [2:0]          bidx, bidx_n;
    logic [7:0]          shift, shift_n;
    logic [7:0]          head;
    logic                push, pop, bit_end;

    // full is the pre-edge flag, so a push while full is refused even if a pop coincides
    assign push = t.wr_en && !full;
    assign head = mem[rptr[DEPTH_LOG2-1:0]];

    assign wptr_n  = wptr + {{DEPTH_LOG2{1'b0}}, push};
    assign rptr_n  = rptr + {{DEPTH_LOG2{1'b0}}, pop};
    assign level_n = wptr_n - rptr_n;
    assign empty_n = (wptr_n == rptr_n);
    assign full_n  = (wptr_n[DEPTH_LOG2] != rptr_n[DEPTH_LOG2]) &&
                     (wptr_n[DEPTH_LOG2-1:0] == rptr_n[DEPTH_LOG2-1:0]);

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= t.wr_data;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            level <= level_n;
            full  <= full_n;
            empty <= empty_n;
            if (t.wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            tick   <= '0;
            bidx   <= '0;
            shift  <= '0;
            tx_out <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            tick   <= tick_n;
            bidx   <= bidx_n;
            shift  <= shift_n;
            tx_out <= tx_n;
            busy   <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick + CNT_W'(1);
        bidx_n  = bidx;
        shift_n = shift;
        tx_n    = tx_out;
        pop     = 1'b0;
        bit_end = (tick == LAST_TICK);
        unique case (state)
            IDLE: begin
                tick_n = '0;
                tx_n   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    bidx_n  = '0;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tick_n  = '0;
                    tx_n    = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_n = '0;
                    if (bidx != 3'd7) begin
                        shift_n = shift >> 1;
                        tx_n    = shift[1];
                        bidx_n  = bidx + 3'd1;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tick_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        bidx_n  = '0;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign t.full     = full;
    assign t.empty    = empty;
    assign t.level    = level;
    assign t.overflow = overflow;
    assign t.busy     = busy;
    assign t.tx_out   = tx_out;
endmodule

// File: tb/tb_tweet_tx.sv
// Scoreboard bench for tweet_tx at a 4-cycle bit time.
// A line monitor decodes frames and compares them against queued bytes.
module tb_tweet_tx;
    localparam int BT = 4;
    localparam int DL = 4;

    logic sysclk;
    logic reset;

    tweet_tx_if #(.DEPTH_LOG2(DL)) t ();

    tweet_tx #(
        .BIT_TICKS (BT),
        .CNT_W     (3),
        .DEPTH_LOG2(DL)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .t     (t)
    );

    int checks;
    int errors;
    int frames;
    logic [7:0] sb[$];
    logic mon_en;

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line monitor: cycle-accurate frame decode, sampled on the falling edge
    logic       m_act;
    int         m_cyc;
    logic [9:0] m_fr;
    logic       m_bad;

    always @(negedge sysclk) begin
        if (!reset || !mon_en) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (t.tx_out == 1'b0) begin
                m_act = 1'b1;
                m_fr  = '0;
                m_bad = 1'b0;
                m_cyc = 1;
            end
        end else begin
            if (m_cyc % BT == 0) begin
                m_fr[m_cyc / BT] = t.tx_out;
            end else if (t.tx_out !== m_fr[m_cyc / BT]) begin
                m_bad = 1'b1;
            end
            if (m_cyc == 10 * BT - 1) begin
                m_act = 1'b0;
                frames++;
                chk("stop_bit", m_fr[9], 1);
                chk("bit_stable", m_bad, 0);
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    chk("frame_byte", m_fr[8:1], sb.pop_front());
                end
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((t.busy || !t.empty) && n < 3000) begin
            @(negedge sysclk);
            n++;
        end
        chk(tag, n < 3000, 1);
        repeat (3) @(negedge sysclk);
    endtask

    task automatic busy_len(input string tag, input int exp);
        int n;
        n = 0;
        while (t.busy && n < 500) begin
            @(negedge sysclk);
            n++;
        end
        chk(tag, n, exp);
    endtask

    initial begin
        int f0;
        logic quiet;
        checks = 0;
        errors = 0;
        frames = 0;
        mon_en = 1'b0;
        reset = 1'b0;
        t.wr_en = 1'b0;
        t.wr_data = 8'h00;

        // reset values and quiet line
        repeat (5) @(negedge sysclk);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge sysclk);
        chk("rst_tx", t.tx_out, 1);
        chk("rst_busy", t.busy, 0);
        chk("rst_empty", t.empty, 1);
        chk("rst_full", t.full, 0);
        chk("rst_level", t.level, 0);
        chk("rst_ovf", t.overflow, 0);
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            if (t.tx_out !== 1'b1 || t.busy !== 1'b0) quiet = 1'b0;
        end
        chk("rst_quiet", quiet, 1);

        // single byte
        f0 = frames;
        t.wr_en = 1'b1;
        t.wr_data = 8'h41;
        sb.push_back(8'h41);
        @(negedge sysclk);
        t.wr_en = 1'b0;
        chk("s_empty_e0", t.empty, 0);
        chk("s_tx_e0", t.tx_out, 1);
        chk("s_busy_e0", t.busy, 0);
        @(negedge sysclk);
        chk("s_tx_e1", t.tx_out, 0);
        chk("s_busy_e1", t.busy, 1);
        chk("s_level_e1", t.level, 0);
        busy_len("s_busy_len", 10 * BT);
        drain("s_drain");
        chk("s_frames", frames - f0, 1);

        // back-to-back frames
        f0 = frames;
        t.wr_en = 1'b1;
        t.wr_data = 8'h48;
        sb.push_back(8'h48);
        @(negedge sysclk);
        t.wr_data = 8'h69;
        sb.push_back(8'h69);
        @(negedge sysclk);
        t.wr_en = 1'b0;
        chk("b_level_e1", t.level, 1);
        busy_len("b_busy_len", 20 * BT);
        drain("b_drain");
        chk("b_level_end", t.level, 0);
        chk("b_frames", frames - f0, 2);

        // push on the same edge that the stop bit pops
        f0 = frames;
        t.wr_en = 1'b1;
        t.wr_data = 8'h55;
        sb.push_back(8'h55);
        @(negedge sysclk);
        t.wr_en = 1'b0;
        @(negedge sysclk);
        t.wr_en = 1'b1;
        t.wr_data = 8'hA3;
        sb.push_back(8'hA3);
        @(negedge sysclk);
        t.wr_en = 1'b0;
        repeat (10 * BT - 2) @(negedge sysclk);
        chk("p_stop_tx", t.tx_out, 1);
        chk("p_level_pre", t.level, 1);
        t.wr_en = 1'b1;
        t.wr_data = 8'h0F;
        sb.push_back(8'h0F);
        @(negedge sysclk);
        t.wr_en = 1'b0;
        chk("p_level_post", t.level, 1);
        chk("p_start_tx", t.tx_out, 0);
        chk("p_busy", t.busy, 1);
        drain("p_drain");
        chk("p_frames", frames - f0, 3);

        // fill past capacity
        f0 = frames;
        for (int i = 0; i < 18; i++) begin
            t.wr_en = 1'b1;
            t.wr_data = 8'(i);
            if (i < 17) sb.push_back(8'(i));
            @(negedge sysclk);
            if (i == 0) chk("f_tx_e0", t.tx_out, 1);
            if (i == 15) chk("f_full_e15", t.full, 0);
            if (i == 16) begin
                chk("f_full_e16", t.full, 1);
                chk("f_level_e16", t.level, 16);
                chk("f_ovf_e16", t.overflow, 0);
            end
            if (i == 17) begin
                chk("f_ovf_e17", t.overflow, 1);
                chk("f_level_e17", t.level, 16);
            end
        end
        t.wr_en = 1'b0;
        drain("f_drain");
        chk("f_frames", frames - f0, 17);
        chk("f_ovf_sticky", t.overflow, 1);

        // reset during data bit 3 of 0x5A with 3 bytes queued
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t.wr_en = 1'b1;
            t.wr_data = (i == 0) ? 8'h5A : 8'(i);
            @(negedge sysclk);
        end
        t.wr_en = 1'b0;
        repeat (14) @(negedge sysclk);
        chk("r_busy_pre", t.busy, 1);
        chk("r_level_pre", t.level, 3);
        @(negedge sysclk);
        chk("r_bit3", t.tx_out, 1);
        @(negedge sysclk);
        chk("r_bit3b", t.tx_out, 1);
        @(posedge sysclk);
        #2;
        reset = 1'b0;
        #1;
        chk("r_tx_now", t.tx_out, 1);
        chk("r_level_now", t.level, 0);
        chk("r_busy_now", t.busy, 0);
        chk("r_ovf_now", t.overflow, 0);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (t.tx_out !== 1'b1 || t.busy !== 1'b0) quiet = 1'b0;
        end
        chk("r_quiet", quiet, 1);
        chk("r_empty", t.empty, 1);

        chk("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tweet_tx.md
# tweet_tx

Buffered 8N1 serial transmitter that drives the tweetboard's serial input line. It is the sending end of the link. Upstream logic (keypad scanner, canned-message ROM walker) pushes ASCII bytes, including backspace 0x08, into a small FIFO. The block serialises each byte LSB-first at the board's bit rate, so that it matches the receiver's mid-bit sampling.

## Interface

Parameters:
- BIT_TICKS, 5208: sysclk cycles per serial bit (50 MHz / 9600 baud).
- CNT_W, 13: width of the bit-tick counter; must satisfy 2^CNT_W > BIT_TICKS.
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries (16).

Ports:
- sysclk, input, 1: system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset (low = in reset).
- wr_en, input, 1: push request; sampled on rising sysclk.
- wr_data, input, 8: byte to push.
- full, output, 1: FIFO holds 2^DEPTH_LOG2 bytes.
- empty, output, 1: FIFO holds 0 bytes.
- level, output, DEPTH_LOG2+1: current FIFO occupancy.
- overflow, output, 1: sticky; a push was dropped because full.
- busy, output, 1: transmitter is mid-frame (state != IDLE).
- tx_out, output, 1: serial line; idles high; registered.

## Operation

- **Reset (reset low, asynchronous):**
  - tx_out=1, busy=0, empty=1, full=0, level=0, overflow=0.
  - FIFO pointers are 0 and the FSM is in IDLE.
  - FIFO contents are don't-care.
- **Push:**
  - When wr_en=1 and full=0, wr_data is written at the write pointer and the pointer increments (wraps mod depth).
  - When wr_en=1 and full=1, the byte is dropped and overflow is set to 1.
  - overflow clears only on reset.
  - full is evaluated on the pre-edge state. A push while full is rejected even if a pop happens on the same edge.
- **Pop:** performed only by the FSM, as described below.
  - Push and pop on the same edge with full=0: both occur, and level is unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** tx_out=1. If empty=0: pop the head byte into the shift register, clear the tick counter and bit index, drive tx_out=0, then go to START.
  - **START:** hold tx_out=0. When tick==BIT_TICKS-1: clear tick, drive tx_out=shift[0], then go to DATA.
  - **DATA:** when tick==BIT_TICKS-1:
    - If bit index < 7: shift right, drive the next bit, increment the index.
    - Else: drive tx_out=1 and go to STOP.
  - **STOP:** hold tx_out=1. When tick==BIT_TICKS-1:
    - If empty=0: pop, load, drive tx_out=0, go to START (back-to-back frames, no gap).
    - Else: go to IDLE.
- The tick counter is CNT_W bits, counts 0..BIT_TICKS-1, and is cleared at every bit boundary.
- The bit index is 3 bits.
- level = write pointer − read pointer, computed with one extra wrap bit. full and empty are derived from that same extra bit.
- No parity. Bytes are sent unmodified; 0x08 gets no special handling.

## Timing

- A push on edge E0 into an empty FIFO with the FSM idle makes empty=0 after E0. The FSM pops on E1, and tx_out falls after E1. Write-to-start-bit latency is 1 cycle.
- Each bit is exactly BIT_TICKS cycles. A frame is 10·BIT_TICKS cycles: start, 8 data bits LSB first, stop.
- busy rises on the same edge that tx_out falls for the start bit. It falls on the edge that ends STOP with the FIFO empty.
- Consecutive frames are contiguous: the stop bit's last cycle is immediately followed by the next start bit.
- tx_out, busy and the flags come straight from registers. No combinational path runs from inputs to outputs.
- Reset mid-frame truncates the frame: tx_out goes high immediately and the queued bytes are lost. After release, the line stays high until a new push.

## Test plan

- **Reset values:** hold reset low 5 cycles, then release -> tx_out=1, busy=0, empty=1, full=0, level=0, overflow=0, and no activity for 100 cycles.
- **Single byte (BIT_TICKS=4):** push 0x41 at E0.
  - tx_out falls after E1.
  - Line sequence in 4-cycle bits: 0 \| 1,0,0,0,0,0,1,0 \| 1.
  - busy=0 exactly 40 cycles after E1.
- **Back-to-back (BIT_TICKS=4):** push 0x48, then 0x69 on consecutive edges.
  - Two 40-cycle frames with no idle cycle between them.
  - busy stays high for 80 cycles.
  - level returns to 0.
- **Full/overflow (BIT_TICKS=4, depth 16):** push 18 bytes 0x00..0x11 on consecutive edges.
  - Byte 0x00 pops on E1.
  - full=1 after E16, with level=16.
  - 0x11 is dropped and overflow=1.
  - Exactly 17 frames are sent: 0x00..0x10.
- **Simultaneous push/pop:** with level=1 and the FSM in STOP's last tick, push on that edge -> level stays 1, and the next frame starts with no gap.
- **Reset mid-frame:** assert reset during data bit 3 of 0x5A with 3 bytes queued.
  - tx_out=1 and level=0 immediately.
  - After release with no pushes, tx_out stays 1 for 200 cycles.
